// File: rtl/param_seq_alu_if.sv
// Request/response bundle for param_seq_alu.
//   Request side : in_valid, in_ready, alu_ctrl, dport1, dport2
//   Response side: out_valid, out_ready, alu_out, flags {N,Z,C,V}, illegal_op
// master = the requester/consumer; slave = the ALU.
interface param_seq_alu_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] dport1;
  logic [WIDTH-1:0] dport2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       flags;
  logic             illegal_op;

  modport master (
    output in_valid, alu_ctrl, dport1, dport2, out_ready,
    input  in_ready, out_valid, alu_out, flags, illegal_op
  );

  modport slave (
    input  in_valid, alu_ctrl, dport1, dport2, out_ready,
    output in_ready, out_valid, alu_out, flags, illegal_op
  );
endinterface

// File: rtl/param_seq_alu.sv
// Sequential ALU with a valid/ready request and a valid/ready result.
// Single-cycle ops (ADD, SUB, AND, OR, XOR, NOT, illegal, zero-length
// shifts) finish one cycle after acceptance; shifts move one bit per cycle
// and MUL is an unsigned shift-add taking WIDTH cycles.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - param_seq_alu_if slave modport (request, result, flags)
module param_seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic            clk,
  input logic            rst_n,
  param_seq_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3, OP_XOR = 4'd4,
    OP_NOT = 4'd5, OP_SLA = 4'd6, OP_SRA = 4'd7, OP_SRL = 4'd8, OP_MUL = 4'd9
  } op_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;        // operand A, doubles as shift register
  logic [2*WIDTH-1:0] prod_q, prod_d;  // {partial sum, remaining multiplier}
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [3:0]         flags_q, flags_d;
  logic               ill_q, ill_d;

  logic [WIDTH:0]     sum_w, diff_w, mul_sum;
  logic [SHW-1:0]     sh_amt;
  logic [WIDTH-1:0]   r;
  logic               c, v, c_sh, finish;

  assign sum_w   = {1'b0, bus.dport1} + {1'b0, bus.dport2};
  assign diff_w  = {1'b0, bus.dport1} - {1'b0, bus.dport2};
  assign sh_amt  = bus.dport2[SHW-1:0];
  // One shift-add step: add A to the upper half when the current multiplier
  // bit is set, then shift the whole product register right.
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);

  // NOTE: every _d and temporary gets a default before any branch so no
  // path leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flags_d = flags_q;
    ill_d   = ill_q;
    r       = '0;
    c       = 1'b0;
    v       = 1'b0;
    c_sh    = 1'b0;
    finish  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d   = op_e'(bus.alu_ctrl);
          a_d    = bus.dport1;
          finish = 1'b1;
          ill_d  = 1'b0;
          case (op_e'(bus.alu_ctrl))
            OP_ADD: begin
              r = sum_w[WIDTH-1:0];
              c = sum_w[WIDTH];
              v = (bus.dport1[WIDTH-1] == bus.dport2[WIDTH-1]) &&
                  (sum_w[WIDTH-1] != bus.dport1[WIDTH-1]);
            end
            OP_SUB: begin
              r = diff_w[WIDTH-1:0];
              c = diff_w[WIDTH];  // borrow out of the unsigned subtract
              v = (bus.dport1[WIDTH-1] != bus.dport2[WIDTH-1]) &&
                  (diff_w[WIDTH-1] != bus.dport1[WIDTH-1]);
            end
            OP_AND: r = bus.dport1 & bus.dport2;
            OP_OR:  r = bus.dport1 | bus.dport2;
            OP_XOR: r = bus.dport1 ^ bus.dport2;
            OP_NOT: r = ~bus.dport1;
            OP_SLA, OP_SRA, OP_SRL: begin
              if (sh_amt == '0) begin
                r = bus.dport1;
              end else begin
                finish  = 1'b0;
                cnt_d   = CW'(sh_amt);
                state_d = BUSY;
              end
            end
            OP_MUL: begin
              finish  = 1'b0;
              prod_d  = {{WIDTH{1'b0}}, bus.dport2};
              cnt_d   = CW'(WIDTH);
              state_d = BUSY;
            end
            default: ill_d = 1'b1;  // result 0 yields flags 4'b0100
          endcase
        end
      end

      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        case (op_q)
          OP_SLA: begin a_d = {a_q[WIDTH-2:0], 1'b0};    c_sh = a_q[WIDTH-1]; end
          OP_SRA: begin a_d = {a_q[WIDTH-1], a_q[WIDTH-1:1]}; c_sh = a_q[0]; end
          OP_SRL: begin a_d = {1'b0, a_q[WIDTH-1:1]};    c_sh = a_q[0]; end
          OP_MUL: prod_d = {mul_sum, prod_q[WIDTH-1:1]};
          default: ;
        endcase
        if (cnt_q == CW'(1)) begin
          finish = 1'b1;
          if (op_q == OP_MUL) begin
            r = prod_d[WIDTH-1:0];
            c = |prod_d[2*WIDTH-1:WIDTH];
          end else begin
            r = a_d;
            c = c_sh;
          end
        end
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d = DONE;
      res_d   = r;
      flags_d = {r[WIDTH-1], ~|r, c, v};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the same pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      ill_q   <= ill_d;
    end
  end

  // Gated by rst_n so the requester never sees ready while reset is held.
  assign bus.in_ready   = (state_q == IDLE) && rst_n;
  assign bus.out_valid  = (state_q == DONE);
  assign bus.alu_out    = res_q;
  assign bus.flags      = flags_q;
  assign bus.illegal_op = ill_q;
endmodule

// File: tb/tb_param_seq_alu.sv
// Directed bench for param_seq_alu at WIDTH=16 with hand-computed results.
module tb_param_seq_alu;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  param_seq_alu_if #(.WIDTH(16)) bus ();

  param_seq_alu #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request with out_ready held high; check latency and result.
  task automatic issue(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input int exp_lat, input logic [15:0] exp_out,
                       input logic [3:0] exp_flags, input logic exp_ill);
    int lat;
    bus.alu_ctrl = op;
    bus.dport1   = a;
    bus.dport2   = b;
    bus.in_valid = 1'b1;
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      step();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " alu_out"}, 32'(bus.alu_out), 32'(exp_out));
    check({tag, " flags"}, 32'(bus.flags), 32'(exp_flags));
    check({tag, " illegal"}, 32'(bus.illegal_op), 32'(exp_ill));
    step();  // DONE -> IDLE on this edge
    check({tag, " back idle"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_ctrl  = 4'd0;
    bus.dport1    = '0;
    bus.dport2    = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    check("rst in_ready low", 32'(bus.in_ready), 32'd0);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst alu_out", 32'(bus.alu_out), 32'd0);
    check("rst flags", 32'(bus.flags), 32'd0);
    check("rst illegal", 32'(bus.illegal_op), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post-rst in_ready", 32'(bus.in_ready), 32'd1);

    //     tag         op     A         B        lat  out       NZCV     ill
    issue("add ovf",  4'd0, 16'h7FFF, 16'h0001, 1,  16'h8000, 4'b1001, 1'b0);
    issue("add cry",  4'd0, 16'hFFFF, 16'h0001, 1,  16'h0000, 4'b0110, 1'b0);
    issue("sub neg",  4'd1, 16'h0003, 16'h0005, 1,  16'hFFFE, 4'b1010, 1'b0);
    issue("sub zero", 4'd1, 16'h0005, 16'h0005, 1,  16'h0000, 4'b0100, 1'b0);
    issue("sub ovf",  4'd1, 16'h8000, 16'h0001, 1,  16'h7FFF, 4'b0001, 1'b0);
    issue("or",       4'd3, 16'hF000, 16'h000F, 1,  16'hF00F, 4'b1000, 1'b0);
    issue("xor",      4'd4, 16'hAAAA, 16'hAAAA, 1,  16'h0000, 4'b0100, 1'b0);
    issue("not",      4'd5, 16'h00FF, 16'h1234, 1,  16'hFF00, 4'b1000, 1'b0);
    issue("sra 3",    4'd7, 16'h8001, 16'h0003, 4,  16'hF000, 4'b1000, 1'b0);
    issue("srl 0",    4'd8, 16'h8001, 16'h0000, 1,  16'h8001, 4'b1000, 1'b0);
    issue("srl 1",    4'd8, 16'h8001, 16'h0001, 2,  16'h4000, 4'b0010, 1'b0);
    issue("sla 4",    4'd6, 16'h9001, 16'h0004, 5,  16'h0010, 4'b0010, 1'b0);
    issue("sra 15",   4'd7, 16'h8000, 16'h000F, 16, 16'hFFFF, 4'b1000, 1'b0);
    issue("mul",      4'd9, 16'h1234, 16'h0100, 17, 16'h3400, 4'b0010, 1'b0);
    issue("mul max",  4'd9, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 4'b0010, 1'b0);
    issue("illegal",  4'hC, 16'h1234, 16'h5678, 1,  16'h0000, 4'b0100, 1'b1);

    // Back-pressure: result held, new requests ignored until out_ready.
    bus.out_ready = 1'b0;
    issue_stall();

    // Reset in the middle of a multiply.
    bus.alu_ctrl = 4'd9;
    bus.dport1   = 16'h1234;
    bus.dport2   = 16'h0100;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("mid-mul busy", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst in_ready gated", 32'(bus.in_ready), 32'd0);
    step();
    check("abort out_valid", 32'(bus.out_valid), 32'd0);
    check("abort alu_out", 32'(bus.alu_out), 32'd0);
    check("abort flags", 32'(bus.flags), 32'd0);
    check("abort illegal", 32'(bus.illegal_op), 32'd0);
    rst_n = 1'b1;
    #1;
    check("abort in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (bus.out_valid) seen++;
    end
    check("no stale out_valid", 32'(seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic issue_stall();
    int lat;
    bus.alu_ctrl = 4'd2;
    bus.dport1   = 16'hF0F0;
    bus.dport2   = 16'h0FF0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      step();
      lat++;
    end
    check("and latency", 32'(lat), 32'd1);
    // A competing request while the result waits.
    bus.alu_ctrl = 4'd0;
    bus.dport1   = 16'h1111;
    bus.dport2   = 16'h2222;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall alu_out", 32'(bus.alu_out), 32'h00F0);
      check("stall flags", 32'(bus.flags), 32'd0);
      check("stall in_ready", 32'(bus.in_ready), 32'd0);
      check("stall out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("release out_valid", 32'(bus.out_valid), 32'd0);
    check("release in_ready", 32'(bus.in_ready), 32'd1);
    check("ignored req", 32'(bus.alu_out), 32'h00F0);
  endtask
endmodule

// File: doc/param_seq_alu.md
PARAM_SEQ_ALU -- requirements
Module: param_seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data path width in bits (legal values 8, 16, 32).
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), meaning width of the shift-amount field taken from dport2[SHW-1:0].
REQ-003 The block SHALL have port clk, input, 1, meaning single rising-edge clock for all state.
REQ-004 The block SHALL have port rst_n, input, 1, meaning synchronous active-low reset sampled on the rising edge of clk.
REQ-005 The block SHALL have port in_valid, input, 1, meaning an operation request is present.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts a request this cycle.
REQ-007 The block SHALL have port alu_ctrl, input, 4, meaning opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SLA, 7 SRA, 8 SRL, 9 MUL; 10-15 are illegal.
REQ-008 The block SHALL have ports dport1 and dport2, each input, WIDTH, meaning operand A and operand B.
REQ-009 The block SHALL have port out_valid, output, 1, meaning alu_out, flags and illegal_op hold a completed result.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-011 The block SHALL have port alu_out, output, WIDTH, meaning operation result.
REQ-012 The block SHALL have port flags, output, 4, meaning {N, Z, C, V}.
REQ-013 The block SHALL have port illegal_op, output, 1, meaning the completed operation had an illegal opcode.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-015 The in_ready output SHALL be 1 only in IDLE; a request is accepted when in_valid and in_ready are both 1 on a rising edge, and opcode and operands are registered.
REQ-016 ADD, SUB, AND, OR, XOR, NOT, illegal opcodes and shifts with amount 0 SHALL go IDLE->DONE, so out_valid rises 1 cycle after acceptance.
REQ-017 For SLA, SRA and SRL with amount k = dport2[SHW-1:0] > 0, the block SHALL go IDLE->BUSY and shift 1 bit per cycle, then DONE; out_valid rises k+1 cycles after acceptance.
REQ-018 SLA SHALL shift left with zero fill, SRA SHALL shift right replicating the MSB, and SRL SHALL shift right with zero fill.
REQ-019 MUL SHALL be unsigned shift-add over WIDTH BUSY cycles, and alu_out SHALL be the low WIDTH bits of the product; out_valid rises WIDTH+1 cycles after acceptance.
REQ-020 The C flag SHALL be set as follows: ADD gives the carry-out; SUB gives the borrow (1 when dport1 < dport2 unsigned); shifts give the last bit shifted out, or 0 when k = 0; MUL gives 1 when the high product half is nonzero; all other ops give 0.
REQ-021 The V flag SHALL be signed overflow for ADD and SUB, and 0 for all other ops.
REQ-022 The N flag SHALL equal alu_out[WIDTH-1], and the Z flag SHALL be 1 when alu_out is all zeros, for every op.
REQ-023 For an illegal opcode, the block SHALL drive alu_out = 0, flags = 4'b0100 and illegal_op = 1.
REQ-024 In DONE, out_valid SHALL be 1 and alu_out, flags and illegal_op SHALL be held stable until out_ready = 1.
REQ-025 When out_ready = 1 in DONE, the block SHALL move to IDLE on that edge and accept no new request in the same cycle, so issue rate is at most 1 per 2 cycles.
REQ-026 Input changes while the block is in BUSY or DONE SHALL have no effect.
REQ-027 All arithmetic SHALL be modulo 2^WIDTH, with no output wider than declared.

Reset
REQ-028 When rst_n = 0 on a rising edge, the FSM SHALL enter IDLE and the block SHALL drive out_valid = 0, alu_out = 0, flags = 0, illegal_op = 0 and in_ready = 1 in the following cycle.
REQ-029 Reset asserted in BUSY or DONE SHALL abort the operation, discard the result and produce no out_valid pulse.
REQ-030 in_ready SHALL be 0 while rst_n = 0.

Verification
REQ-031 With WIDTH=16, ADD 0x7FFF + 0x0001 and out_ready held at 1 -> 1 cycle after acceptance, alu_out = 0x8000 and flags N=1, Z=0, C=0, V=1.
REQ-032 SUB 0x0003 - 0x0005 -> alu_out = 0xFFFE, N=1, C=1, V=0; then SUB 0x0005 - 0x0005 -> alu_out = 0, Z=1, C=0.
REQ-033 SRA 0x8001 by 3 -> out_valid 4 cycles after acceptance, alu_out = 0xF000, C=0; SRL 0x8001 by 0 -> 1 cycle, alu_out = 0x8001, C=0.
REQ-034 MUL 0x1234 x 0x0100 -> out_valid 17 cycles after acceptance, alu_out = 0x3400, C=1.
REQ-035 out_ready held at 0 for 5 cycles after AND 0xF0F0 & 0x0FF0 -> alu_out stays 0x00F0, in_ready stays 0, and a second in_valid is ignored until out_ready = 1.
REQ-036 Opcode 0xC, then rst_n pulsed low mid-MUL -> first returns alu_out = 0, Z=1, illegal_op = 1; after the reset pulse, all outputs are 0, in_ready = 1, and no stale out_valid appears.
